// File: rtl/kitchen_timer_pkg.sv
// ---------------------------------------------------------------------------
// kitchen_timer_pkg
//   Shared definitions for the kitchen timer core: controller state type,
//   7-segment code table (active-low {g,f,e,d,c,b,a}) and BCD MM:SS helpers.
//   No ports; imported by kitchen_timer_core and its display scanner.
// ---------------------------------------------------------------------------
package kitchen_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } timer_state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digits 0-9 have a glyph; the six non-BCD codes show nothing.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    SEG_BLANK, SEG_BLANK, SEG_BLANK,
    SEG_BLANK, SEG_BLANK, SEG_BLANK
  };

  // A usable preset has every nibble in 0-9 and seconds tens in 0-5.
  function automatic logic bcd_valid_mmss(input logic [7:0] mm, input logic [7:0] ss);
    return (mm[7:4] <= 4'd9) && (mm[3:0] <= 4'd9) &&
           (ss[7:4] <= 4'd5) && (ss[3:0] <= 4'd9);
  endfunction

  // One-second BCD decrement of {min tens, min ones, sec tens, sec ones}.
  // Callers guarantee the value is non-zero, so the final min-tens borrow
  // can never underflow.
  function automatic logic [15:0] bcd_dec_mmss(input logic [15:0] c);
    logic [15:0] d;
    d = c;
    if (d[3:0] != 4'd0) begin
      d[3:0] = d[3:0] - 4'd1;
    end else begin
      d[3:0] = 4'd9;
      if (d[7:4] != 4'd0) begin
        d[7:4] = d[7:4] - 4'd1;
      end else begin
        d[7:4] = 4'd5;
        if (d[11:8] != 4'd0) begin
          d[11:8] = d[11:8] - 4'd1;
        end else begin
          d[11:8]  = 4'd9;
          d[15:12] = d[15:12] - 4'd1;
        end
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/kitchen_timer_core_seg7_scan.sv
// ---------------------------------------------------------------------------
// kitchen_timer_core_seg7_scan
//   Free-running 4-digit multiplexer. Advances one digit slot every SCAN_DIV
//   clocks (order 0,1,2,3,0...) and registers AN and cathode together so the
//   segment pattern never lags the digit enable.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_digit0..3       BCD digits, 0 = rightmost (seconds ones)
//   i_blank           blank the whole display (all anodes off)
//   o_an              active-low one-hot digit enables
//   o_cathode         active-low segments {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module kitchen_timer_core_seg7_scan
  import kitchen_timer_pkg::*;
#(
  parameter int SCAN_DIV = 100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_digit0,
  input  logic [3:0] i_digit1,
  input  logic [3:0] i_digit2,
  input  logic [3:0] i_digit3,
  input  logic       i_blank,
  output logic [3:0] o_an,
  output logic [6:0] o_cathode
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [SW-1:0] r_scanCnt;
  logic [1:0]    r_slot;
  logic          w_scanWrap;
  logic [1:0]    w_slotNext;
  logic [3:0]    w_digit;

  assign w_scanWrap = (r_scanCnt == SW'(SCAN_DIV - 1));
  assign w_slotNext = w_scanWrap ? (r_slot + 2'd1) : r_slot;

  // The digit is chosen from the slot being entered, so the cathode
  // register receives the glyph that matches the anode it is paired with.
  always_comb begin
    w_digit = i_digit0;
    case (w_slotNext)
      2'd1:    w_digit = i_digit1;
      2'd2:    w_digit = i_digit2;
      2'd3:    w_digit = i_digit3;
      default: w_digit = i_digit0;
    endcase
  end

  // Slot divider plus the output registers; blanking drops every anode and
  // every segment for the whole blanked period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scanCnt <= '0;
      r_slot    <= 2'd0;
      o_an      <= 4'b1110;
      o_cathode <= 7'b1000000;
    end else begin
      r_scanCnt <= w_scanWrap ? '0 : (r_scanCnt + SW'(1));
      r_slot    <= w_slotNext;
      if (i_blank) begin
        o_an      <= 4'b1111;
        o_cathode <= SEG_BLANK;
      end else begin
        o_an      <= ~(4'b0001 << w_slotNext);
        o_cathode <= SEG_LUT[w_digit];
      end
    end
  end

endmodule

// File: rtl/kitchen_timer_core.sv
// ---------------------------------------------------------------------------
// kitchen_timer_core
//   BCD MM:SS countdown timer with load/start/pause/clear pulses, a timed
//   alarm output and a blinking 4-digit multiplexed 7-segment display.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   preset_min, preset_sec  BCD preset {tens, ones}
//   load, start, pause,     single-cycle command pulses
//   clear                   (priority clear > load > start > pause)
//   cathode                 active-low segments {g,f,e,d,c,b,a}
//   AN                      active-low digit enables, AN[0] = seconds ones
//   timeUp                  alarm, high for ALARM_SECS seconds after expiry
//   running                 high while counting down
//   load_err                one-cycle pulse when a preset is rejected
// ---------------------------------------------------------------------------
module kitchen_timer_core
  import kitchen_timer_pkg::*;
#(
  parameter int TICK_DIV   = 100_000_000,
  parameter int SCAN_DIV   = 100_000,
  parameter int ALARM_SECS = 10,
  parameter int BLINK_DIV  = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [6:0] cathode,
  output logic [3:0] AN,
  output logic       timeUp,
  output logic       running,
  output logic       load_err
);

  localparam int TW = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
  localparam int BW = (BLINK_DIV > 1)  ? $clog2(BLINK_DIV)  : 1;
  localparam int AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;

  if (TICK_DIV < 2) begin : g_tickDivCheck
    $error("kitchen_timer_core: TICK_DIV must be at least 2");
  end
  if (SCAN_DIV < 2) begin : g_scanDivCheck
    $error("kitchen_timer_core: SCAN_DIV must be at least 2");
  end
  if (BLINK_DIV < 2) begin : g_blinkDivCheck
    $error("kitchen_timer_core: BLINK_DIV must be at least 2");
  end
  if (ALARM_SECS < 1) begin : g_alarmCheck
    $error("kitchen_timer_core: ALARM_SECS must be at least 1");
  end

  timer_state_t  r_state, w_stateNext;
  logic [15:0]   r_count, w_countNext;
  logic [TW-1:0] r_tickCnt, w_tickNext;
  logic [AW-1:0] r_alarmCnt, w_alarmNext;
  logic [BW-1:0] r_blinkCnt, w_blinkCntNext;
  logic          r_blinkPhase, w_blinkPhaseNext;
  logic          r_timeUp, w_timeUpNext;
  logic          r_running;
  logic          r_loadErr, w_loadErrNext;

  logic          w_tickWrap;
  logic          w_blinkWrap;
  logic          w_alarmLast;
  logic          w_presetOk;
  logic [15:0]   w_decCount;
  logic          w_blank;

  assign w_tickWrap  = (r_tickCnt == TW'(TICK_DIV - 1));
  assign w_blinkWrap = (r_blinkCnt == BW'(BLINK_DIV - 1));
  assign w_alarmLast = (r_alarmCnt == AW'(ALARM_SECS - 1));
  assign w_presetOk  = bcd_valid_mmss(preset_min, preset_sec);
  assign w_decCount  = bcd_dec_mmss(r_count);

  // State and datapath registers. Everything the outside world sees is
  // taken from a flop so the board pins never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_count      <= 16'h0000;
      r_tickCnt    <= '0;
      r_alarmCnt   <= '0;
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b0;
      r_timeUp     <= 1'b0;
      r_running    <= 1'b0;
      r_loadErr    <= 1'b0;
    end else begin
      r_state      <= w_stateNext;
      r_count      <= w_countNext;
      r_tickCnt    <= w_tickNext;
      r_alarmCnt   <= w_alarmNext;
      r_blinkCnt   <= w_blinkCntNext;
      r_blinkPhase <= w_blinkPhaseNext;
      r_timeUp     <= w_timeUpNext;
      r_running    <= (w_stateNext == ST_RUNNING);
      r_loadErr    <= w_loadErrNext;
    end
  end

  // Next-state logic. First the per-state background activity (countdown
  // in RUNNING, alarm and blink timing in EXPIRED), then at most one command
  // overrides it, highest priority first. A lower-priority pulse arriving
  // with a higher one is dropped even if the higher one has no effect.
  always_comb begin
    w_stateNext      = r_state;
    w_countNext      = r_count;
    w_tickNext       = r_tickCnt;
    w_alarmNext      = r_alarmCnt;
    w_blinkCntNext   = r_blinkCnt;
    w_blinkPhaseNext = r_blinkPhase;
    w_timeUpNext     = r_timeUp;
    w_loadErrNext    = 1'b0;

    case (r_state)
      ST_RUNNING: begin
        if (w_tickWrap) begin
          w_tickNext = '0;
          if (r_count != 16'h0000) begin
            w_countNext = w_decCount;
            // Reaching zero expires on the same edge; the tick counter has
            // just wrapped, so it doubles as the alarm-second timer.
            if (w_decCount == 16'h0000) begin
              w_stateNext      = ST_EXPIRED;
              w_alarmNext      = '0;
              w_timeUpNext     = 1'b1;
              w_blinkCntNext   = '0;
              w_blinkPhaseNext = 1'b0;
            end
          end
        end else begin
          w_tickNext = r_tickCnt + TW'(1);
        end
      end
      ST_EXPIRED: begin
        if (w_blinkWrap) begin
          w_blinkCntNext   = '0;
          w_blinkPhaseNext = ~r_blinkPhase;
        end else begin
          w_blinkCntNext = r_blinkCnt + BW'(1);
        end
        if (r_timeUp) begin
          if (w_tickWrap) begin
            w_tickNext = '0;
            if (w_alarmLast) begin
              w_timeUpNext = 1'b0;
              w_alarmNext  = '0;
            end else begin
              w_alarmNext = r_alarmCnt + AW'(1);
            end
          end else begin
            w_tickNext = r_tickCnt + TW'(1);
          end
        end
      end
      default: begin
      end
    endcase

    if (clear) begin
      w_stateNext      = ST_IDLE;
      w_countNext      = 16'h0000;
      w_tickNext       = '0;
      w_alarmNext      = '0;
      w_timeUpNext     = 1'b0;
      w_blinkCntNext   = '0;
      w_blinkPhaseNext = 1'b0;
    end else if (load) begin
      if (r_state != ST_RUNNING) begin
        if (w_presetOk) begin
          w_stateNext      = ST_IDLE;
          w_countNext      = {preset_min, preset_sec};
          w_tickNext       = '0;
          w_alarmNext      = '0;
          w_timeUpNext     = 1'b0;
          w_blinkCntNext   = '0;
          w_blinkPhaseNext = 1'b0;
        end else begin
          w_loadErrNext = 1'b1;
        end
      end
    end else if (start) begin
      if (((r_state == ST_IDLE) || (r_state == ST_PAUSED)) && (r_count != 16'h0000)) begin
        w_stateNext = ST_RUNNING;
        // A fresh run starts a whole second; a resume keeps the partial one.
        if (r_state == ST_IDLE) begin
          w_tickNext = '0;
        end
      end
    end else if (pause) begin
      if (r_state == ST_RUNNING) begin
        w_stateNext      = ST_PAUSED;
        w_countNext      = r_count;
        w_tickNext       = r_tickCnt;
        w_alarmNext      = r_alarmCnt;
        w_timeUpNext     = r_timeUp;
        w_blinkCntNext   = r_blinkCnt;
        w_blinkPhaseNext = r_blinkPhase;
      end
    end
  end

  // The scanner is fed next-cycle values so its registered outputs line up
  // with the state and count registers on the same edge.
  assign w_blank = (w_stateNext == ST_EXPIRED) && w_blinkPhaseNext;

  kitchen_timer_core_seg7_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_digit0 (w_countNext[3:0]),
    .i_digit1 (w_countNext[7:4]),
    .i_digit2 (w_countNext[11:8]),
    .i_digit3 (w_countNext[15:12]),
    .i_blank  (w_blank),
    .o_an     (AN),
    .o_cathode(cathode)
  );

  assign timeUp   = r_timeUp;
  assign running  = r_running;
  assign load_err = r_loadErr;

endmodule

// File: tb/tb_kitchen_timer_core.sv
// ---------------------------------------------------------------------------
// tb_kitchen_timer_core
//   Directed stimulus for kitchen_timer_core with a seconds-based reference
//   model compared against every output on every cycle, plus hand-computed
//   checkpoints on the model and on the decoded display.
// ---------------------------------------------------------------------------
module tb_kitchen_timer_core;

  localparam int TICK_DIV   = 10;
  localparam int SCAN_DIV   = 2;
  localparam int ALARM_SECS = 3;
  localparam int BLINK_DIV  = 5;

  localparam int M_IDLE    = 0;
  localparam int M_RUN     = 1;
  localparam int M_PAUSED  = 2;
  localparam int M_EXPIRED = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] preset_min = 8'h00;
  logic [7:0] preset_sec = 8'h00;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       clear = 1'b0;
  logic [6:0] cathode;
  logic [3:0] AN;
  logic       timeUp;
  logic       running;
  logic       load_err;

  int assertCount = 0;
  int failCount   = 0;
  bit checkEn     = 1'b0;

  // Reference model state: remaining time in plain seconds.
  int mMode       = M_IDLE;
  int mSecs       = 0;
  int mPhase      = 0;
  int mAlarmLeft  = 0;
  int mExpCycles  = 0;
  int mScanCycles = 0;
  bit mLoadErr    = 1'b0;

  always #5 clk = ~clk;

  kitchen_timer_core #(
    .TICK_DIV  (TICK_DIV),
    .SCAN_DIV  (SCAN_DIV),
    .ALARM_SECS(ALARM_SECS),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .preset_min(preset_min),
    .preset_sec(preset_sec),
    .load      (load),
    .start     (start),
    .pause     (pause),
    .clear     (clear),
    .cathode   (cathode),
    .AN        (AN),
    .timeUp    (timeUp),
    .running   (running),
    .load_err  (load_err)
  );

  function automatic logic [6:0] segOf(input int d);
    case (d)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] segDecode(input logic [6:0] seg);
    for (int d = 0; d < 10; d++) begin
      if (segOf(d) == seg) return 4'(d);
    end
    return 4'hF;
  endfunction

  function automatic int expDigit(input int slot);
    int mm;
    int ss;
    mm = mSecs / 60;
    ss = mSecs % 60;
    case (slot)
      0:       return ss % 10;
      1:       return ss / 10;
      2:       return mm % 10;
      default: return mm / 10;
    endcase
  endfunction

  function automatic bit expBlank();
    return (mMode == M_EXPIRED) && (((mExpCycles / BLINK_DIV) % 2) == 1);
  endfunction

  function automatic logic [3:0] expAN();
    int slot;
    slot = (mScanCycles / SCAN_DIV) % 4;
    if (expBlank()) return 4'b1111;
    return ~(4'b0001 << slot);
  endfunction

  function automatic logic [6:0] expCathode();
    if (expBlank()) return 7'b1111111;
    return segOf(expDigit((mScanCycles / SCAN_DIV) % 4));
  endfunction

  // Reference model, advanced once per clock from the sampled command pulses.
  always @(posedge clk or negedge rst_n) begin : modelStep
    int nMode, nSecs, nPhase, nAlarm, nExp;
    int mt, mo, st, so;
    bit nErr, taken;
    if (!rst_n) begin
      mMode       <= M_IDLE;
      mSecs       <= 0;
      mPhase      <= 0;
      mAlarmLeft  <= 0;
      mExpCycles  <= 0;
      mScanCycles <= 0;
      mLoadErr    <= 1'b0;
    end else begin
      nMode  = mMode;
      nSecs  = mSecs;
      nPhase = mPhase;
      nAlarm = mAlarmLeft;
      nExp   = mExpCycles;
      nErr   = 1'b0;
      taken  = 1'b0;
      mt = int'(preset_min) / 16;
      mo = int'(preset_min) % 16;
      st = int'(preset_sec) / 16;
      so = int'(preset_sec) % 16;
      if (clear) begin
        nMode = M_IDLE; nSecs = 0; nPhase = 0; nAlarm = 0;
        taken = 1'b1;
      end else if (load && mMode != M_RUN) begin
        if (mt <= 9 && mo <= 9 && st <= 5 && so <= 9) begin
          nMode = M_IDLE; nSecs = (mt * 10 + mo) * 60 + st * 10 + so;
          nPhase = 0; nAlarm = 0;
          taken = 1'b1;
        end else begin
          nErr = 1'b1;
        end
      end else if (load) begin
        taken = 1'b0;
      end else if (start && (mMode == M_IDLE || mMode == M_PAUSED) && mSecs != 0) begin
        if (mMode == M_IDLE) nPhase = 0;
        nMode = M_RUN;
        taken = 1'b1;
      end else if (!start && pause && mMode == M_RUN) begin
        nMode = M_PAUSED;
        taken = 1'b1;
      end
      if (!taken) begin
        if (mMode == M_RUN) begin
          nPhase = mPhase + 1;
          if (nPhase == TICK_DIV) begin
            nPhase = 0;
            nSecs  = mSecs - 1;
            if (nSecs == 0) begin
              nMode  = M_EXPIRED;
              nAlarm = ALARM_SECS * TICK_DIV;
              nExp   = 0;
            end
          end
        end else if (mMode == M_EXPIRED) begin
          nExp = mExpCycles + 1;
          if (mAlarmLeft > 0) nAlarm = mAlarmLeft - 1;
        end
      end
      mMode       <= nMode;
      mSecs       <= nSecs;
      mPhase      <= nPhase;
      mAlarmLeft  <= nAlarm;
      mExpCycles  <= nExp;
      mScanCycles <= mScanCycles + 1;
      mLoadErr    <= nErr;
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every output against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (checkEn && rst_n) begin
      checkOutput("cyc_AN",       16'(AN),       16'(expAN()));
      checkOutput("cyc_cathode",  16'(cathode),  16'(expCathode()));
      checkOutput("cyc_timeUp",   16'(timeUp),   16'((mMode == M_EXPIRED) && (mAlarmLeft > 0)));
      checkOutput("cyc_running",  16'(running),  16'(mMode == M_RUN));
      checkOutput("cyc_load_err", 16'(load_err), 16'(mLoadErr));
    end
  end

  // Drives one command cycle; called and returns on a falling edge.
  task automatic applyStimulus(input bit ld, input bit st, input bit pa, input bit cl,
                               input logic [7:0] mn, input logic [7:0] sc);
    preset_min = mn;
    preset_sec = sc;
    load  = ld;
    start = st;
    pause = pa;
    clear = cl;
    @(negedge clk);
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    clear = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reassembles the displayed BCD value over one full scan round.
  task automatic readDisplay(output logic [15:0] bcd);
    bcd = 16'hFFFF;
    for (int i = 0; i < 4 * SCAN_DIV; i++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        if (AN == ~(4'b0001 << d)) bcd[d*4 +: 4] = segDecode(cathode);
      end
    end
  endtask

  initial begin
    logic [15:0] disp;
    int highCnt;
    int runCnt;

    #2 rst_n = 1'b0;
    #1;
    $display("[TB] reset applied");
    checkOutput("rst_AN",       16'(AN),       16'h000E);
    checkOutput("rst_cathode",  16'(cathode),  16'h0040);
    checkOutput("rst_timeUp",   16'(timeUp),   16'h0000);
    checkOutput("rst_running",  16'(running),  16'h0000);
    checkOutput("rst_load_err", 16'(load_err), 16'h0000);
    @(negedge clk);
    rst_n   = 1'b1;
    checkEn = 1'b1;

    $display("[TB] 00:12 countdown and alarm window");
    applyStimulus(1, 0, 0, 0, 8'h00, 8'h12);
    checkOutput("mdl_load12", 16'(mSecs), 16'd12);
    applyStimulus(0, 1, 0, 0, 8'h00, 8'h00);
    checkOutput("run_after_start", 16'(running), 16'h0001);
    waitCycles(9);
    checkOutput("mdl_12_at9", 16'(mSecs), 16'd12);
    waitCycles(1);
    checkOutput("mdl_11_at10", 16'(mSecs), 16'd11);
    readDisplay(disp);
    checkOutput("disp_0011", disp, 16'h0011);
    waitCycles(101);
    checkOutput("timeUp_before", 16'(timeUp), 16'h0000);
    checkOutput("run_before_exp", 16'(running), 16'h0001);
    waitCycles(1);
    checkOutput("timeUp_at120", 16'(timeUp), 16'h0001);
    checkOutput("run_expired", 16'(running), 16'h0000);
    highCnt = 1;
    for (int i = 1; i <= 40; i++) begin
      waitCycles(1);
      if (timeUp) highCnt++;
      if (i == 7)  checkOutput("blink_off", 16'(AN), 16'h000F);
      if (i == 12) checkOutput("blink_on", 16'(AN == 4'b1111), 16'h0000);
    end
    checkOutput("alarm_len", 16'(highCnt), 16'd30);

    $display("[TB] 01:00 ten ticks, then 10:00 borrow chain");
    applyStimulus(1, 0, 0, 0, 8'h01, 8'h00);
    checkOutput("load_exp_timeUp", 16'(timeUp), 16'h0000);
    applyStimulus(0, 1, 0, 0, 8'h00, 8'h00);
    waitCycles(100);
    checkOutput("mdl_050", 16'(mSecs), 16'd50);
    readDisplay(disp);
    checkOutput("disp_0050", disp, 16'h0050);
    applyStimulus(0, 0, 1, 0, 8'h00, 8'h00);
    checkOutput("run_paused", 16'(running), 16'h0000);
    applyStimulus(1, 0, 0, 0, 8'h10, 8'h00);
    applyStimulus(0, 1, 0, 0, 8'h00, 8'h00);
    waitCycles(10);
    checkOutput("mdl_0959", 16'(mSecs), 16'd599);
    readDisplay(disp);
    checkOutput("disp_0959", disp, 16'h0959);

    $display("[TB] pause mid-tick and resume");
    applyStimulus(0, 0, 1, 0, 8'h00, 8'h00);
    applyStimulus(1, 0, 0, 0, 8'h00, 8'h30);
    applyStimulus(0, 1, 0, 0, 8'h00, 8'h00);
    waitCycles(4);
    applyStimulus(0, 0, 1, 0, 8'h00, 8'h00);
    runCnt = 0;
    for (int i = 0; i < 50; i++) begin
      waitCycles(1);
      if (running) runCnt++;
    end
    checkOutput("pause_running", 16'(runCnt), 16'd0);
    checkOutput("mdl_pause_30", 16'(mSecs), 16'd30);
    applyStimulus(0, 1, 0, 0, 8'h00, 8'h00);
    waitCycles(5);
    checkOutput("mdl_resume5", 16'(mSecs), 16'd30);
    waitCycles(1);
    checkOutput("mdl_resume6", 16'(mSecs), 16'd29);

    $display("[TB] rejected and ignored loads");
    applyStimulus(0, 0, 1, 0, 8'h00, 8'h00);
    applyStimulus(1, 0, 0, 0, 8'h1A, 8'h60);
    checkOutput("load_err_pulse", 16'(load_err), 16'h0001);
    waitCycles(1);
    checkOutput("load_err_drop", 16'(load_err), 16'h0000);
    checkOutput("mdl_bad_load", 16'(mSecs), 16'd29);
    readDisplay(disp);
    checkOutput("disp_0029", disp, 16'h0029);
    applyStimulus(0, 1, 0, 0, 8'h00, 8'h00);
    applyStimulus(1, 0, 0, 0, 8'h00, 8'h45);
    checkOutput("load_run_noerr", 16'(load_err), 16'h0000);
    checkOutput("load_run_keeps", 16'(running), 16'h0001);

    $display("[TB] coincident clear/load/start and start at zero");
    applyStimulus(1, 1, 0, 1, 8'h00, 8'h45);
    checkOutput("clr_running", 16'(running), 16'h0000);
    checkOutput("mdl_clr_zero", 16'(mSecs), 16'd0);
    readDisplay(disp);
    checkOutput("disp_0000", disp, 16'h0000);
    applyStimulus(0, 1, 0, 0, 8'h00, 8'h00);
    checkOutput("start_zero_idle", 16'(running), 16'h0000);

    $display("[TB] asynchronous reset during alarm");
    applyStimulus(1, 0, 0, 0, 8'h00, 8'h01);
    applyStimulus(0, 1, 0, 0, 8'h00, 8'h00);
    waitCycles(10);
    checkOutput("short_expired", 16'(timeUp), 16'h0001);
    waitCycles(12);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_AN",       16'(AN),       16'h000E);
    checkOutput("arst_cathode",  16'(cathode),  16'h0040);
    checkOutput("arst_timeUp",   16'(timeUp),   16'h0000);
    checkOutput("arst_running",  16'(running),  16'h0000);
    checkOutput("arst_load_err", 16'(load_err), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    waitCycles(20);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/kitchen_timer_core.md
Name: kitchen_timer_core

Overview:
- Parametrised successor to the single-purpose ramen timer.
- Loads a BCD MM:SS preset, then counts it down at 1 Hz with start, pause and clear controls.
- Drives a 4-digit multiplexed 7-segment display and raises timeUp for a configurable alarm window, blinking the display while expired.
- Sits between the button/switch debounce logic and the board's display pins.

Parameters:
- TICK_DIV, 100_000_000: clk cycles per countdown second.
- SCAN_DIV, 100_000: clk cycles per display digit slot.
- ALARM_SECS, 10: seconds timeUp stays high after expiry.
- BLINK_DIV, 50_000_000: clk cycles per half-period of the expired-display blink.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- preset_min  in  8  BCD minutes {tens, ones}, 00-99
- preset_sec  in  8  BCD seconds {tens, ones}, 00-59
- load  in  1  single-cycle pulse: capture preset
- start  in  1  single-cycle pulse: run/resume
- pause  in  1  single-cycle pulse: freeze
- clear  in  1  single-cycle pulse: abort to IDLE, count=00:00
- cathode  out  7  segments {g,f,e,d,c,b,a}, active-low
- AN  out  4  digit enables, active-low one-hot; AN[0] is the rightmost digit (seconds ones)
- timeUp  out  1  alarm
- running  out  1  high in RUNNING
- load_err  out  1  one-cycle pulse when a preset is rejected

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset values:
  - state=IDLE, count=00:00, all dividers=0.
  - AN=4'b1110, cathode=7'b1000000 (digit "0").
  - timeUp=0, running=0, load_err=0.
- All outputs are registered.
- States: IDLE, RUNNING, PAUSED, EXPIRED. Command priority when pulses coincide: clear > load > start > pause.
- clear, from any state: go to IDLE, count=00:00, tick and alarm counters=0, timeUp=0.
- load, valid only in IDLE, PAUSED or EXPIRED:
  - Preset is valid when every BCD nibble is ≤9 and sec tens ≤5.
  - Valid preset: count=preset and state goes to IDLE next cycle.
  - Invalid preset: count unchanged; load_err=1 for exactly one cycle.
  - load in RUNNING is ignored, with no load_err.
- start, from IDLE or PAUSED with count≠00:00: go to RUNNING.
  - From IDLE, the tick counter is zeroed, so the first decrement occurs TICK_DIV cycles after start.
  - From PAUSED, the tick counter resumes from its held value.
  - start with count=00:00 is ignored.
  - start in EXPIRED is ignored; only clear or load leaves EXPIRED.
- pause, in RUNNING: go to PAUSED, tick counter held. Ignored in other states.
- RUNNING decrement:
  - Tick counter counts 0..TICK_DIV-1; on the wrap cycle, count decrements by one second in BCD.
  - Borrows: sec ones 0→9 with borrow; sec tens 0→5 with borrow; min ones 0→9 with borrow; min tens decrements.
  - When the decrement yields 00:00, state becomes EXPIRED on the same edge.
  - The count never wraps below 00:00.
- EXPIRED:
  - timeUp=1 from the cycle EXPIRED is entered, for exactly ALARM_SECS×TICK_DIV cycles, then 0; the state remains EXPIRED.
  - Display shows 00:00, blanked (AN=4'b1111) on alternate BLINK_DIV periods, starting visible.
- Scan:
  - A digit slot advances every SCAN_DIV cycles in the order 0,1,2,3,0…
  - Scanning free-runs in all states.
  - cathode updates on the same edge as AN, so there is no ghosting cycle.
  - The min tens digit is displayed even when it is 0.
- Counter widths: $clog2 of each divider parameter. Assert every divider ≥2 at elaboration.
- Asserting rst_n mid-count aborts immediately to the reset values.

Decomposition:
- Package kitchen_timer_pkg:
  - state enum.
  - SEG_BLANK=7'b1111111.
  - 16-entry BCD-to-segment constant (0-9 valid; codes ≥10 map to SEG_BLANK).
  - Function bcd_valid_mmss.
- Sub-module seg7_scan: handles SCAN_DIV, the digit counter, the blink mask input and the AN/cathode registers. Takes four 4-bit BCD digits plus a blank enable.

Test Plan (TICK_DIV=10, SCAN_DIV=2, ALARM_SECS=3, BLINK_DIV=5):
- Reset → AN=1110, cathode=1000000, timeUp=0. Load 00:12, start → count 00:11 exactly 10 cycles after start; 00:00 after 120 cycles; timeUp high for exactly 30 cycles.
- Load 01:00, start, 10 ticks → 00:50. Load 10:00, 1 tick → 09:59 (full borrow chain).
- Start, pause at cycle 4 of a tick, wait 50 cycles, start → next decrement 6 cycles later; running=0 throughout the pause.
- Load with min=8'h1A, sec=8'h60 → load_err single-cycle pulse, count unchanged. Load during RUNNING → ignored, no load_err.
- clear, load and start asserted in the same cycle → IDLE, 00:00. Start with 00:00 → stays IDLE.
- EXPIRED: AN alternates between scanning and 1111 every 5 cycles. rst_n low mid-alarm → outputs at reset values asynchronously, before the next clk edge.
